// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard beside Decode: tracks in-flight destinations and
// produces stall, forwarded operands and pending-forward flags per read port.
module hazard_scoreboard #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NST    = 3,
  parameter int TW     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [AW-1:0]         d_a3,
  input  logic [TW-1:0]         d_tnew,
  input  logic [NRD*AW-1:0]     d_ra,
  input  logic [NRD*TW-1:0]     d_tuse,
  input  logic [NRD*DATA_W-1:0] d_rf,
  input  logic [NST*DATA_W-1:0] st_wd,
  input  logic                  flush,
  output logic                  stall,
  output logic [NRD*DATA_W-1:0] d_fwd,
  output logic [NRD-1:0]        d_pend,
  output logic [NST*AW-1:0]     st_a3,
  output logic [NST*TW-1:0]     st_tnew
);

  logic [NST-1:0][AW-1:0] a3_q, a3_d;
  logic [NST-1:0][TW-1:0] tnew_q, tnew_d;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Slot shift: slot 0 takes Decode only when it actually advances
  always_comb begin
    a3_d   = '0;
    tnew_d = '0;
    if (issue && !stall && !flush) begin
      a3_d[0]   = d_a3;
      tnew_d[0] = d_tnew;
    end
    for (int k = 1; k < NST; k++) begin
      a3_d[k]   = a3_q[k-1];
      tnew_d[k] = sat_dec(tnew_q[k-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a3_q   <= '0;
      tnew_q <= '0;
    end else begin
      a3_q   <= a3_d;
      tnew_q <= tnew_d;
    end
  end

  assign st_a3   = a3_q;
  assign st_tnew = tnew_q;

  // Per-port resolution against the youngest matching producer
  always_comb begin
    logic [AW-1:0] ra;
    logic [TW-1:0] tuse;
    logic          found;
    int            win;
    stall  = 1'b0;
    d_fwd  = d_rf;
    d_pend = '0;
    for (int i = 0; i < NRD; i++) begin
      ra    = d_ra[i*AW +: AW];
      tuse  = d_tuse[i*TW +: TW];
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < NST; k++) begin
        if (!found && ra != '0 && a3_q[k] == ra) begin
          found = 1'b1;
          win   = k;
        end
      end
      if (found) begin
        if (tnew_q[win] == '0) begin
          d_fwd[i*DATA_W +: DATA_W] = st_wd[win*DATA_W +: DATA_W];
        end else begin
          d_pend[i] = 1'b1;
          if (tnew_q[win] > tuse) stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        reset, issue, flush;
  logic [4:0]  d_a3;
  logic [1:0]  d_tnew;
  logic [9:0]  d_ra;
  logic [3:0]  d_tuse;
  logic [63:0] d_rf;
  logic [95:0] st_wd;
  logic        stall;
  logic [63:0] d_fwd;
  logic [1:0]  d_pend;
  logic [14:0] st_a3;
  logic [5:0]  st_tnew;
  int checks = 0;
  int failures = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue(issue), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_ra(d_ra), .d_tuse(d_tuse), .d_rf(d_rf), .st_wd(st_wd), .flush(flush),
    .stall(stall), .d_fwd(d_fwd), .d_pend(d_pend), .st_a3(st_a3), .st_tnew(st_tnew)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue = 1'b0; flush = 1'b0; d_a3 = '0; d_tnew = '0;
    d_ra = '0; d_tuse = '0;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic issue_op(input logic [4:0] a3, input logic [1:0] tn);
    idle();
    issue = 1'b1; d_a3 = a3; d_tnew = tn;
    step();
  endtask

  task automatic read0(input logic [4:0] ra, input logic [1:0] tu);
    issue = 1'b1; flush = 1'b0; d_a3 = '0; d_tnew = '0;
    d_ra = {5'd0, ra}; d_tuse = {2'd0, tu};
    #1;
  endtask

  initial begin
    reset = 1'b0; idle();
    d_ra = {5'd9, 5'd8}; d_rf = {32'h22, 32'h11}; st_wd = '0;
    repeat (2) step();
    chk("rst_st_a3", {17'd0, st_a3}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_pend", {30'd0, d_pend}, 32'd0);
    chk("rst_fwd0", d_fwd[31:0], 32'h11);
    chk("rst_fwd1", d_fwd[63:32], 32'h22);
    reset = 1'b1;
    drain();

    // Tnew 1, Tuse 1: pending without stall, then forwarded from slot 1
    issue_op(5'd8, 2'd1);
    read0(5'd8, 2'd1);
    chk("t1_st_a3_0", {27'd0, st_a3[4:0]}, 32'd8);
    chk("t1_st_tnew_0", {30'd0, st_tnew[1:0]}, 32'd1);
    chk("t1_stall", {31'd0, stall}, 32'd0);
    chk("t1_pend", {30'd0, d_pend}, 32'd1);
    chk("t1_fwd_rf", d_fwd[31:0], 32'h11);
    step();
    st_wd = {32'h0, 32'hABCD, 32'h0};
    #1;
    chk("t1_fwd_wd1", d_fwd[31:0], 32'hABCD);
    chk("t1_pend2", {30'd0, d_pend}, 32'd0);
    chk("t1_stall2", {31'd0, stall}, 32'd0);
    drain();

    // Load Tnew 2, user Tuse 1: one stall cycle
    issue_op(5'd9, 2'd2);
    read0(5'd9, 2'd1);
    chk("t2_stall_c1", {31'd0, stall}, 32'd1);
    step();
    chk("t2_stall_c2", {31'd0, stall}, 32'd0);
    chk("t2_pend_c2", {30'd0, d_pend}, 32'd1);
    chk("t2_bubble", {27'd0, st_a3[4:0]}, 32'd0);
    drain();

    // Load Tnew 2, branch Tuse 0: two stall cycles, then slot 2 forwards
    issue_op(5'd9, 2'd2);
    read0(5'd9, 2'd0);
    chk("t3_stall_c1", {31'd0, stall}, 32'd1);
    step();
    chk("t3_stall_c2", {31'd0, stall}, 32'd1);
    step();
    st_wd = {32'h5555, 32'h0, 32'h0};
    #1;
    chk("t3_stall_c3", {31'd0, stall}, 32'd0);
    chk("t3_pend_c3", {30'd0, d_pend}, 32'd0);
    chk("t3_fwd_wd2", d_fwd[31:0], 32'h5555);
    drain();

    // Two producers of r5: youngest (slot 0) wins
    issue_op(5'd5, 2'd0);
    issue_op(5'd5, 2'd0);
    idle();
    st_wd = {32'h0, 32'hB, 32'hA};
    d_ra = {5'd0, 5'd5};
    #1;
    chk("t4_fwd_young", d_fwd[31:0], 32'hA);
    chk("t4_stall", {31'd0, stall}, 32'd0);
    drain();

    // Register 0 never stalls or forwards
    issue_op(5'd0, 2'd2);
    read0(5'd0, 2'd0);
    chk("t5_stall", {31'd0, stall}, 32'd0);
    chk("t5_pend", {30'd0, d_pend}, 32'd0);
    chk("t5_fwd", d_fwd[31:0], 32'h11);
    drain();

    // Flush beats issue
    idle();
    issue = 1'b1; flush = 1'b1; d_a3 = 5'd7; d_tnew = 2'd2;
    step();
    read0(5'd7, 2'd0);
    chk("t6_st_a3_0", {27'd0, st_a3[4:0]}, 32'd0);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_pend", {30'd0, d_pend}, 32'd0);
    chk("t6_fwd", d_fwd[31:0], 32'h11);
    drain();

    // Reset mid-stall clears the slots
    issue_op(5'd9, 2'd2);
    read0(5'd9, 2'd0);
    chk("t7_stall_pre", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("t7_stall_post", {31'd0, stall}, 32'd0);
    chk("t7_st_a3", {17'd0, st_a3}, 32'd0);
    chk("t7_st_tnew", {26'd0, st_tnew}, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
